// File: rtl/toy_burst_loader.sv
// -----------------------------------------------------------------------------
// toy_burst_loader
//
// This module loads a burst of DEPTH words, each DATA_W bits wide, over a
// valid/ready handshake into an internal register bank. When the bank is full,
// the loader locks and refuses further input. A registered read port lets
// downstream toy datapaths read the stored words as configuration or seed
// values.
//
// Build option:
//   TOY_LOADER_REARM_EN
//     - Defined: 'rearm' in DONE unlocks the loader, so the block can be
//       reloaded any number of times.
//     - Undefined: DONE is terminal until 'reset' (load-once behaviour).
//       'rearm' is ignored.
//     - The port list is the same in both builds.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high reset
//   in_data    in   DATA_W  word to load
//   in_valid   in   1       in_data is valid
//   in_ready   out  1       loader accepts a word this cycle (state != DONE)
//   rearm      in   1       unlock request (only honoured with the build option)
//   loaded     out  1       bank is full and locked (state == DONE)
//   word_count out  CW      words accepted since the last reset or rearm
//   rd_addr    in   AW      read address
//   rd_data    out  DATA_W  registered read data (0 for out-of-range address)
// -----------------------------------------------------------------------------
module toy_burst_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rearm,
  output logic              loaded,
  output logic [CW-1:0]     word_count,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [CW-1:0] LP_DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LP_ONE_C   = CW'(1);
  localparam logic [CW-1:0] LP_ZERO_C  = CW'(0);
  localparam logic [AW:0]   LP_DEPTH_A = (AW + 1)'(DEPTH);

  state_t              r_state;
  logic [CW-1:0]       r_word_count;
  logic [DATA_W-1:0]   r_bank [DEPTH];
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_xfer;
  logic [CW-1:0]       w_count_inc;
  logic [AW-1:0]       w_wr_idx;
  logic                w_last_xfer;
  logic                w_rd_in_range;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_rearm_hit;

  // Handshake flags are decoded straight from the registered state.
  assign in_ready   = (r_state != ST_DONE);
  assign loaded     = (r_state == ST_DONE);
  assign word_count = r_word_count;
  assign rd_data    = r_rd_data;

  // Decode transfer, write index and burst completion.
  always_comb begin
    w_xfer      = in_valid & in_ready;
    w_count_inc = r_word_count + LP_ONE_C;
    // word_count is below DEPTH whenever a write happens, so its low AW bits
    // address the bank directly.
    w_wr_idx    = r_word_count[AW-1:0];
    if (w_count_inc == LP_DEPTH_C) begin
      w_last_xfer = 1'b1;
    end else begin
      w_last_xfer = 1'b0;
    end
  end

  // Select read data; an address past the last entry reads as zero.
  always_comb begin
    w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH_A);
    if (w_rd_in_range) begin
      w_rd_word = r_bank[rd_addr];
    end else begin
      w_rd_word = '0;
    end
  end

`ifdef TOY_LOADER_REARM_EN
  // Rearm request is live only in this build.
  always_comb begin
    w_rearm_hit = rearm;
  end
`else
  // Rearm is functionally unconnected in the load-once build.
  logic w_unused_rearm;
  assign w_unused_rearm = rearm;

  // Tie off the rearm request in the load-once build.
  always_comb begin
    w_rearm_hit = 1'b0;
  end
`endif

  // Loader FSM, word counter, register bank and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_word_count <= LP_ZERO_C;
      r_rd_data    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      // Sampled before any same-cycle write lands, so the read returns the
      // old contents.
      r_rd_data <= w_rd_word;

      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_bank[0]    <= in_data;
            r_word_count <= LP_ONE_C;
            r_state      <= (DEPTH == 1) ? ST_DONE : ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          // Gaps simply hold state and count; there is no timeout.
          if (w_xfer) begin
            r_bank[w_wr_idx] <= in_data;
            r_word_count     <= w_count_inc;
            if (w_last_xfer) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_LOAD;
            end
          end else begin
            r_state <= ST_LOAD;
          end
        end

        ST_DONE: begin
          // The bank is kept on rearm; only the count restarts.
          if (w_rearm_hit) begin
            r_state      <= ST_IDLE;
            r_word_count <= LP_ZERO_C;
          end else begin
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_word_count <= LP_ZERO_C;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toy_burst_loader.sv
// -----------------------------------------------------------------------------
// tb_toy_burst_loader
//
// This is a directed, self-checking bench for toy_burst_loader.
//   - Instance u_dut_4 uses DATA_W=8 and DEPTH=4. It covers the main scenarios.
//   - Instance u_dut_3 uses DEPTH=3. It covers the out-of-range read address.
//
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_toy_burst_loader;

  logic       clk;
  logic       reset;

  logic [7:0] in_data_s;
  logic       in_valid_s;
  logic       in_ready_s;
  logic       rearm_s;
  logic       loaded_s;
  logic [2:0] word_count_s;
  logic [1:0] rd_addr_s;
  logic [7:0] rd_data_s;

  logic [7:0] b_in_data_s;
  logic       b_in_valid_s;
  logic       b_in_ready_s;
  logic       b_loaded_s;
  logic [1:0] b_word_count_s;
  logic [1:0] b_rd_addr_s;
  logic [7:0] b_rd_data_s;

  int n_checks;
  int n_errors;

  toy_burst_loader #(.DATA_W(8), .DEPTH(4)) u_dut_4 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data_s),
    .in_valid   (in_valid_s),
    .in_ready   (in_ready_s),
    .rearm      (rearm_s),
    .loaded     (loaded_s),
    .word_count (word_count_s),
    .rd_addr    (rd_addr_s),
    .rd_data    (rd_data_s)
  );

  toy_burst_loader #(.DATA_W(8), .DEPTH(3)) u_dut_3 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (b_in_data_s),
    .in_valid   (b_in_valid_s),
    .in_ready   (b_in_ready_s),
    .rearm      (1'b0),
    .loaded     (b_loaded_s),
    .word_count (b_word_count_s),
    .rd_addr    (b_rd_addr_s),
    .rd_data    (b_rd_data_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    in_data_s  = d;
    in_valid_s = 1'b1;
    step();
    in_valid_s = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr_s = a;
    step();
    chk_eq(tag, {24'h0, rd_data_s}, {24'h0, exp});
  endtask

  logic [7:0] burst_words [4];

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b0;
    in_data_s    = 8'h00;
    in_valid_s   = 1'b0;
    rearm_s      = 1'b0;
    rd_addr_s    = 2'd0;
    b_in_data_s  = 8'h00;
    b_in_valid_s = 1'b0;
    b_rd_addr_s  = 2'd0;
    burst_words[0] = 8'h11;
    burst_words[1] = 8'h22;
    burst_words[2] = 8'h33;
    burst_words[3] = 8'h44;

    // Reset state.
    do_reset();
    chk_eq("rst_ready",  {31'h0, in_ready_s},   32'd1);
    chk_eq("rst_loaded", {31'h0, loaded_s},     32'd0);
    chk_eq("rst_count",  {29'h0, word_count_s}, 32'd0);
    chk_eq("rst_rdata",  {24'h0, rd_data_s},    32'h0);

    // Back-to-back burst.
    in_valid_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_s = burst_words[i];
      step();
      chk_eq("b2b_count", {29'h0, word_count_s}, i + 1);
    end
    in_valid_s = 1'b0;
    chk_eq("b2b_loaded", {31'h0, loaded_s},   32'd1);
    chk_eq("b2b_ready",  {31'h0, in_ready_s}, 32'd0);
    read_chk("b2b_rd0", 2'd0, 8'h11);
    read_chk("b2b_rd1", 2'd1, 8'h22);
    read_chk("b2b_rd2", 2'd2, 8'h33);
    read_chk("b2b_rd3", 2'd3, 8'h44);

    // Gapped burst, then a word presented while the loader is locked.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(burst_words[i]);
      chk_eq("gap_count", {29'h0, word_count_s}, i + 1);
      step();
      step();
      chk_eq("gap_hold", {29'h0, word_count_s}, i + 1);
    end
    in_data_s  = 8'h55;
    in_valid_s = 1'b1;
    step();
    step();
    in_valid_s = 1'b0;
    chk_eq("gap_count_locked", {29'h0, word_count_s}, 32'd4);
    chk_eq("gap_loaded",       {31'h0, loaded_s},     32'd1);
    read_chk("gap_rd0", 2'd0, 8'h11);
    read_chk("gap_rd1", 2'd1, 8'h22);
    read_chk("gap_rd2", 2'd2, 8'h33);
    read_chk("gap_rd3", 2'd3, 8'h44);

    // Reset in the middle of a burst.
    do_reset();
    push(8'h11);
    push(8'h22);
    chk_eq("mid_count2", {29'h0, word_count_s}, 32'd2);
    chk_eq("mid_loaded", {31'h0, loaded_s},     32'd0);
    do_reset();
    chk_eq("mid_rst_count",  {29'h0, word_count_s}, 32'd0);
    chk_eq("mid_rst_ready",  {31'h0, in_ready_s},   32'd1);
    chk_eq("mid_rst_loaded", {31'h0, loaded_s},     32'd0);
    read_chk("mid_rd0", 2'd0, 8'h00);
    read_chk("mid_rd1", 2'd1, 8'h00);
    read_chk("mid_rd2", 2'd2, 8'h00);
    read_chk("mid_rd3", 2'd3, 8'h00);

    // A same-cycle read and write of address 1 returns the old value.
    push(8'h11);
    rd_addr_s  = 2'd1;
    in_data_s  = 8'h22;
    in_valid_s = 1'b1;
    step();
    in_valid_s = 1'b0;
    chk_eq("rw_same_old", {24'h0, rd_data_s}, 32'h00);
    step();
    chk_eq("rw_same_new", {24'h0, rd_data_s}, 32'h22);

    // Finish filling the bank, then assert rearm.
    push(8'h33);
    push(8'h44);
    chk_eq("fill_loaded", {31'h0, loaded_s}, 32'd1);
`ifdef TOY_LOADER_REARM_EN
    rearm_s = 1'b1;
    step();
    rearm_s = 1'b0;
    chk_eq("rearm_loaded", {31'h0, loaded_s},     32'd0);
    chk_eq("rearm_ready",  {31'h0, in_ready_s},   32'd1);
    chk_eq("rearm_count",  {29'h0, word_count_s}, 32'd0);
    push(8'hA0);
    chk_eq("rearm_count1", {29'h0, word_count_s}, 32'd1);
    read_chk("rearm_rd0", 2'd0, 8'hA0);
    read_chk("rearm_rd1", 2'd1, 8'h22);
`else
    rearm_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("norearm_loaded", {31'h0, loaded_s},     32'd1);
      chk_eq("norearm_ready",  {31'h0, in_ready_s},   32'd0);
      chk_eq("norearm_count",  {29'h0, word_count_s}, 32'd4);
    end
    rearm_s = 1'b0;
    read_chk("norearm_rd0", 2'd0, 8'h11);
`endif

    // DEPTH=3 instance: an out-of-range read address returns zero.
    do_reset();
    b_in_valid_s = 1'b1;
    b_in_data_s  = 8'h01;
    step();
    b_in_data_s  = 8'h02;
    step();
    b_in_data_s  = 8'h03;
    step();
    b_in_valid_s = 1'b0;
    chk_eq("d3_loaded", {31'h0, b_loaded_s},     32'd1);
    chk_eq("d3_count",  {30'h0, b_word_count_s}, 32'd3);
    b_rd_addr_s = 2'd2;
    step();
    chk_eq("d3_rd2", {24'h0, b_rd_data_s}, 32'h03);
    b_rd_addr_s = 2'd3;
    step();
    chk_eq("d3_rd3_oor", {24'h0, b_rd_data_s}, 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
